cga_raster_source: RTL and testbench
====================================

Name: cga_raster_source

Overview:
- Generates the low-resolution arcade raster (hsync/vsync/hblank/vblank + 9-bit RGB) that the scan converter consumes.
- Walks a 256x240 frame in a pixel framebuffer, issues one read per active pixel, and aligns the returned data with the delayed sync/blank signals.
- Sits between the game's framebuffer/test-pattern logic and the CGA-side input of the scan converter.
- Used both as a bring-up source and as the video front end for non-native game cores.

Parameters:
- H_TOTAL, 384, pixel clocks per line.
- H_ACTIVE, 256, visible pixels per line, starting at hcount 0.
- H_FP, 16, clocks from end of active to hsync assert.
- H_SYNC, 32, hsync pulse width in clocks.
- V_TOTAL, 262, lines per frame.
- V_ACTIVE, 240, visible lines, starting at vcount 0.
- V_FP, 4, lines from end of active to vsync assert.
- V_SYNC, 4, vsync pulse width in lines.

Ports:
- clk6m, in, 1, pixel clock (single clock domain).
- reset, in, 1, synchronous, active-high.
- pattern_en, in, 1, 1 = output colour bars instead of framebuffer data; sampled once per frame.
- fb_rd, out, 1, framebuffer read strobe.
- fb_addr, out, 16, {line[7:0], pixel[7:0]}.
- fb_data, in, 9, pixel {R[8:6], G[5:3], B[2:0]}, valid exactly 1 clk after fb_rd.
- hsync_o, out, 1, active-high line sync.
- vsync_o, out, 1, active-high frame sync.
- hblank_o, out, 1, 1 outside horizontal active.
- vblank_o, out, 1, 1 outside vertical active.
- rgb_o, out, 9, pixel colour; 0 whenever blanked.
- frame_start, out, 1, one-clock pulse aligned with first active pixel of frame on rgb_o.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - hcount = 0, vcount = 0.
  - hsync_o = 0, vsync_o = 0, hblank_o = 1, vblank_o = 1, rgb_o = 0, fb_rd = 0, fb_addr = 0, frame_start = 0.
  - Pipeline registers are cleared.
  - Reset mid-frame aborts the frame. The first cycle after reset is deasserted is stage-0 hcount=0/vcount=0.
- Counters (stage 0):
  - hcount wraps at H_TOTAL-1 to 0.
  - vcount increments when hcount == H_TOTAL-1 and wraps at V_TOTAL-1 to 0.
  - When both wrap on the same cycle, a new frame starts.
- Stage 0 decode:
  - act = (hcount < H_ACTIVE) & (vcount < V_ACTIVE).
  - hs = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs = vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. vs changes only at line start (hcount 0).
  - fb_rd = act. fb_addr = {vcount[7:0], hcount[7:0]}.
  - Both are registered, so fb_rd/fb_addr appear 1 clk after the counter value.
- Stage 1: fb_data is returned for the stage-0 address. hs/vs/act/hblank/vblank are carried in shift registers.
- Stage 2 (outputs):
  - All outputs are registered.
  - Total latency from counter value to rgb_o/sync = 3 clk (counter, fb_rd register, data return, output register). Sync/blank are delayed identically, so they stay pixel-aligned.
  - rgb_o = act ? (pattern_q ? bars : fb_data) : 0.
- Colour bars: 8 bars of 32 pixels, indexed by hcount[7:5]. Bar n = {n[2],n[2],n[2], n[1],n[1],n[1], n[0],n[0],n[0]}.
- pattern_en sampling: latched into pattern_q when stage-0 hcount == 0 and vcount == 0. Changes mid-frame have no effect until the next frame.
- frame_start: asserted for the output cycle carrying pixel (0,0).
- Sync edges seen by the scan converter: the hsync falling edge occurs once per line, at output hcount H_ACTIVE+H_FP+H_SYNC. No hsync edge occurs inside the active window.
- Width rules:
  - hcount/vcount are 10 bits. Parameters must satisfy H_ACTIVE <= 256, V_ACTIVE <= 256, and H_ACTIVE+H_FP+H_SYNC <= H_TOTAL (same for V).
  - These are checked by elaboration-time assertions.

Decomposition:
- Shared package video_pkg:
  - Default timing constants (H_*/V_*).
  - RGB333 typedef and field slice constants (R 8:6, G 5:3, B 2:0), shared with the scan converter's colour packing.
- Sub-module video_timing_counter:
  - hcount/vcount, wrap, hs/vs/act/blank decode.
  - Reusable for other raster sources.
- The top level holds the fetch pipeline, pattern generator and output registers.

Test Plan:
- Reset release, default params: first fb_rd at clk 1 with fb_addr 0x0000. First rgb_o = fb model value for (0,0) at clk 3, with frame_start = 1.
- Full line count: hblank_o low for exactly 256 consecutive clks and hsync_o high for 32 clks per 384-clk line. Hsync rises 16 clks after hblank rises.
- Full frame: vblank_o low for 240 lines and vsync_o high for 4 lines (1536 clks) starting 4 lines after vblank rises. Frame period = 100608 clks.
- Framebuffer model returns {addr[7:0]^addr[15:8]} zero-extended: every active rgb_o matches the model for its (x,y). rgb_o = 0 during all blanked cycles.
- Toggle pattern_en mid-frame: output stays on framebuffer until the next frame. The following frame shows 0x000, 0x007, 0x038, ... 0x1FF bars at 32-pixel boundaries.
- Assert reset at line 100, pixel 50, for 1 clk: outputs take reset values next clk. The frame restarts at (0,0) and frame_start pulses 3 clks after release.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: default raster timing, RGB333 pixel packing and the
// per-pixel control bundle carried alongside a fetch pipeline.
package video_pkg;

    localparam int H_TOTAL_DEF  = 384;
    localparam int H_ACTIVE_DEF = 256;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 32;
    localparam int V_TOTAL_DEF  = 262;
    localparam int V_ACTIVE_DEF = 240;
    localparam int V_FP_DEF     = 4;
    localparam int V_SYNC_DEF   = 4;

    typedef logic [8:0] rgb333_t;

    localparam int R_MSB = 8;
    localparam int R_LSB = 6;
    localparam int G_MSB = 5;
    localparam int G_LSB = 3;
    localparam int B_MSB = 2;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic       hblank;
        logic       vblank;
        logic       first;
        logic [2:0] bar;
    } raster_ctl_t;

    localparam raster_ctl_t CTL_BLANK = '{act: 1'b0, hs: 1'b0, vs: 1'b0, hblank: 1'b1,
                                          vblank: 1'b1, first: 1'b0, bar: 3'd0};

    // Each bar index bit drives one full colour channel.
    function automatic rgb333_t colour_bar(input logic [2:0] n);
        rgb333_t c;
        c = '0;
        c[R_MSB:R_LSB] = {3{n[2]}};
        c[G_MSB:G_LSB] = {3{n[1]}};
        c[B_MSB:B_LSB] = {3{n[0]}};
        return c;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters with combinational sync/blank/active decode of the
// current position; reusable by any raster source.
module video_timing_counter #(
    parameter int H_TOTAL  = video_pkg::H_TOTAL_DEF,
    parameter int H_ACTIVE = video_pkg::H_ACTIVE_DEF,
    parameter int H_FP     = video_pkg::H_FP_DEF,
    parameter int H_SYNC   = video_pkg::H_SYNC_DEF,
    parameter int V_TOTAL  = video_pkg::V_TOTAL_DEF,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE_DEF,
    parameter int V_FP     = video_pkg::V_FP_DEF,
    parameter int V_SYNC   = video_pkg::V_SYNC_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic [7:0] hpos_o,
    output logic [7:0] vpos_o,
    output logic       act_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       hblank_o,
    output logic       vblank_o,
    output logic       first_o
);

    if (H_ACTIVE > 256 || V_ACTIVE > 256 || H_TOTAL > 1024 || V_TOTAL > 1024 ||
        H_ACTIVE + H_FP + H_SYNC > H_TOTAL || V_ACTIVE + V_FP + V_SYNC > V_TOTAL) begin : g_bad_params
        $error("video_timing_counter: illegal raster timing parameters");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (reset_i) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // vcount only moves at the line wrap, so vs_o can only change at hcount 0.
    assign hblank_o = (hcount_q >= H_ACT);
    assign vblank_o = (vcount_q >= V_ACT);
    assign act_o    = !hblank_o && !vblank_o;
    assign hs_o     = (hcount_q >= HS_BEGIN) && (hcount_q < HS_END);
    assign vs_o     = (vcount_q >= VS_BEGIN) && (vcount_q < VS_END);
    assign first_o  = (hcount_q == '0) && (vcount_q == '0);
    assign hpos_o   = hcount_q[7:0];
    assign vpos_o   = vcount_q[7:0];

endmodule

// File: rtl/cga_raster_source.sv
// Low-resolution arcade raster source: fetches one framebuffer word per active
// pixel and emits sync/blank/RGB333 with all signals aligned three clocks late.
module cga_raster_source
    import video_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF
) (
    input  logic        clk6m,
    input  logic        reset,
    input  logic        pattern_en,
    output logic        fb_rd,
    output logic [15:0] fb_addr,
    input  logic [8:0]  fb_data,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        hblank_o,
    output logic        vblank_o,
    output logic [8:0]  rgb_o,
    output logic        frame_start
);

    logic [7:0]  hpos, vpos;
    logic        act0, hs0, vs0, hblank0, vblank0, first0;
    raster_ctl_t ctl0_d, ctl1_q, ctl2_q;
    logic        pattern_q, pattern_d;
    rgb333_t     rgb_d;

    video_timing_counter #(
        .H_TOTAL (H_TOTAL),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .V_TOTAL (V_TOTAL),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC)
    ) u_timing (
        .clk_i   (clk6m),
        .reset_i (reset),
        .hpos_o  (hpos),
        .vpos_o  (vpos),
        .act_o   (act0),
        .hs_o    (hs0),
        .vs_o    (vs0),
        .hblank_o(hblank0),
        .vblank_o(vblank0),
        .first_o (first0)
    );

    always_comb begin
        ctl0_d = '{act: act0, hs: hs0, vs: vs0, hblank: hblank0,
                   vblank: vblank0, first: first0, bar: hpos[7:5]};
        // Pattern choice is frozen at the top-left pixel so a frame is never mixed.
        pattern_d = first0 ? pattern_en : pattern_q;
        rgb_d = '0;
        if (ctl2_q.act) begin
            rgb_d = pattern_q ? colour_bar(ctl2_q.bar) : fb_data;
        end
    end

    always_ff @(posedge clk6m) begin
        // NOTE: pipeline stages are cleared on reset so an aborted frame cannot leak a stale pixel or sync.
        if (reset) begin
            fb_rd       <= 1'b0;
            fb_addr     <= '0;
            ctl1_q      <= CTL_BLANK;
            ctl2_q      <= CTL_BLANK;
            pattern_q   <= 1'b0;
            hsync_o     <= 1'b0;
            vsync_o     <= 1'b0;
            hblank_o    <= 1'b1;
            vblank_o    <= 1'b1;
            rgb_o       <= '0;
            frame_start <= 1'b0;
        end else begin
            fb_rd       <= ctl0_d.act;
            fb_addr     <= {vpos, hpos};
            ctl1_q      <= ctl0_d;
            ctl2_q      <= ctl1_q;
            pattern_q   <= pattern_d;
            hsync_o     <= ctl2_q.hs;
            vsync_o     <= ctl2_q.vs;
            hblank_o    <= ctl2_q.hblank;
            vblank_o    <= ctl2_q.vblank;
            rgb_o       <= rgb_d;
            frame_start <= ctl2_q.first;
        end
    end

endmodule

// File: tb/tb_cga_raster_source.sv
// Self-checking bench: pixel-arithmetic reference model of the raster, randomized
// framebuffer idle data and randomized pattern_en toggling.
module tb_cga_raster_source;

    // Full default line timing; shortened vertical timing keeps multi-frame runs brief.
    localparam int HT = 384, HA = 256, HF = 16, HS = 32;
    localparam int VT = 26,  VA = 16,  VF = 4,  VS = 4;
    localparam int FRAME = HT * VT;

    localparam logic [8:0] BARS [0:7] = '{9'h000, 9'h007, 9'h038, 9'h03F,
                                          9'h1C0, 9'h1C7, 9'h1F8, 9'h1FF};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
        logic        rd;
        logic [15:0] addr;
        logic [8:0]  rgb;
    } exp_t;

    localparam exp_t RESET_EXP = '{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1, fs: 1'b0,
                                   rd: 1'b0, addr: 16'h0000, rgb: 9'h000};

    logic        clk6m = 1'b0;
    logic        reset;
    logic        pattern_en;
    logic        fb_rd;
    logic [15:0] fb_addr;
    logic [8:0]  fb_data;
    logic        hsync_o, vsync_o, hblank_o, vblank_o, frame_start;
    logic [8:0]  rgb_o;

    int   n_vec = 0;
    int   n_err = 0;
    int   t = 0;
    logic pat_frame [0:15];

    cga_raster_source #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS)
    ) dut (
        .clk6m      (clk6m),
        .reset      (reset),
        .pattern_en (pattern_en),
        .fb_rd      (fb_rd),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .hblank_o   (hblank_o),
        .vblank_o   (vblank_o),
        .rgb_o      (rgb_o),
        .frame_start(frame_start)
    );

    always #5 clk6m = ~clk6m;

    // Framebuffer: answers a read one clock later; random junk when not read.
    always @(posedge clk6m)
        fb_data <= fb_rd ? {1'b0, fb_addr[7:0] ^ fb_addr[15:8]} : 9'($urandom);

    // t = clocks since reset release; pattern_en is captured where each frame begins.
    always @(posedge clk6m) begin
        if (!reset && (t % FRAME) == 0) pat_frame[(t / FRAME) % 16] <= pattern_en;
        t <= reset ? 0 : t + 1;
    end

    function automatic logic [8:0] fb_model(input int x, input int y);
        return {1'b0, 8'(x) ^ 8'(y)};
    endfunction

    // Output at cycle tc shows pixel tc-3; the fetch strobe shows pixel tc-1.
    function automatic exp_t model_at(input int tc);
        exp_t e;
        int   q, x, y, f;
        logic act;
        e = RESET_EXP;
        if (tc >= 1) begin
            q = tc - 1;
            x = q % HT;
            y = (q / HT) % VT;
            e.rd   = (x < HA) && (y < VA);
            e.addr = {8'(y), 8'(x)};
        end
        if (tc >= 3) begin
            q   = tc - 3;
            x   = q % HT;
            y   = (q / HT) % VT;
            f   = q / FRAME;
            act = (x < HA) && (y < VA);
            e.hb = (x >= HA);
            e.vb = (y >= VA);
            e.hs = (x >= HA + HF) && (x < HA + HF + HS);
            e.vs = (y >= VA + VF) && (y < VA + VF + VS);
            e.fs = (x == 0) && (y == 0);
            if (act) e.rgb = pat_frame[f % 16] ? BARS[x / 32] : fb_model(x, y);
        end
        return e;
    endfunction

    task automatic test_reset();
        exp_t obs;
        reset = 1'b1;
        pattern_en = 1'b0;
        repeat (2) @(posedge clk6m);
        @(negedge clk6m);
        reset = 1'b0;
        obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
        n_vec++;
        if (obs !== RESET_EXP) begin
            n_err++;
            $display("FAIL reset_state: got %h, want %h", obs, RESET_EXP);
        end
        @(negedge clk6m);
        n_vec++;
        if (fb_rd !== 1'b1 || fb_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL first_fetch: got rd=%b addr=%h, want rd=1 addr=0000", fb_rd, fb_addr);
        end
        repeat (2) @(negedge clk6m);
        n_vec++;
        if (rgb_o !== fb_model(0, 0) || frame_start !== 1'b1 || hblank_o !== 1'b0) begin
            n_err++;
            $display("FAIL first_pixel: got rgb=%h fs=%b hb=%b, want rgb=%h fs=1 hb=0",
                     rgb_o, frame_start, hblank_o, fb_model(0, 0));
        end
    endtask

    task automatic test_line_timing();
        exp_t obs, e;
        logic hb_s [HT];
        logic hs_s [HT];
        int   guard, hb_low, hs_hi, hb_rise, hs_rise, hs_fall;
        guard = 0;
        while (t != 3 + HT && guard < 4 * HT) begin
            @(negedge clk6m);
            guard++;
        end
        n_vec++;
        if (t != 3 + HT) begin
            n_err++;
            $display("FAIL line_start_wait: got t=%0d, want t=%0d", t, 3 + HT);
        end
        for (int i = 0; i < HT; i++) begin
            e   = model_at(t);
            obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL line_stream t=%0d: got %h, want %h", t, obs, e);
            end
            hb_s[i] = hblank_o;
            hs_s[i] = hsync_o;
            @(negedge clk6m);
        end
        hb_low = 0; hs_hi = 0; hb_rise = -1; hs_rise = -1; hs_fall = -1;
        for (int i = 0; i < HT; i++) begin
            if (hb_s[i] === 1'b0 && hb_low == i) hb_low++;
            if (hs_s[i] === 1'b1) hs_hi++;
            if (i > 0 && hb_s[i] === 1'b1 && hb_s[i-1] === 1'b0 && hb_rise < 0) hb_rise = i;
            if (i > 0 && hs_s[i] === 1'b1 && hs_s[i-1] === 1'b0 && hs_rise < 0) hs_rise = i;
            if (i > 0 && hs_s[i] === 1'b0 && hs_s[i-1] === 1'b1 && hs_fall < 0) hs_fall = i;
        end
        n_vec++;
        if (hb_low != HA) begin
            n_err++;
            $display("FAIL hblank_low_run: got %0d, want %0d", hb_low, HA);
        end
        n_vec++;
        if (hs_hi != HS) begin
            n_err++;
            $display("FAIL hsync_width: got %0d, want %0d", hs_hi, HS);
        end
        n_vec++;
        if (hs_rise - hb_rise != HF || hb_rise != HA) begin
            n_err++;
            $display("FAIL hsync_front_porch: got hb_rise=%0d hs_rise=%0d, want %0d/%0d",
                     hb_rise, hs_rise, HA, HA + HF);
        end
        n_vec++;
        if (hs_fall != HA + HF + HS) begin
            n_err++;
            $display("FAIL hsync_fall: got %0d, want %0d", hs_fall, HA + HF + HS);
        end
    endtask

    task automatic test_frame_timing();
        exp_t obs, e;
        int   guard, vb_low, vs_hi, vb_rise, vs_rise, period;
        logic prev_vb, prev_vs;
        guard = 0;
        while (frame_start !== 1'b1 && guard < 2 * FRAME) begin
            e   = model_at(t);
            obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL frame_stream t=%0d: got %h, want %h", t, obs, e);
            end
            @(negedge clk6m);
            guard++;
        end
        n_vec++;
        if (frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL frame_start_wait: got no pulse in %0d clks, want one", 2 * FRAME);
        end
        vb_low = 0; vs_hi = 0; vb_rise = -1; vs_rise = -1; period = -1;
        prev_vb = vblank_o; prev_vs = vsync_o;
        for (int i = 0; i <= FRAME; i++) begin
            e   = model_at(t);
            obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL frame_stream t=%0d: got %h, want %h", t, obs, e);
            end
            if (i < FRAME) begin
                if (vblank_o === 1'b0) vb_low++;
                if (vsync_o === 1'b1) vs_hi++;
                if (vblank_o === 1'b1 && prev_vb === 1'b0 && vb_rise < 0) vb_rise = i;
                if (vsync_o === 1'b1 && prev_vs === 1'b0 && vs_rise < 0) vs_rise = i;
            end
            if (i > 0 && frame_start === 1'b1 && period < 0) period = i;
            prev_vb = vblank_o;
            prev_vs = vsync_o;
            @(negedge clk6m);
        end
        n_vec++;
        if (vb_low != VA * HT || vb_rise != VA * HT) begin
            n_err++;
            $display("FAIL vblank_active: got low=%0d rise=%0d, want %0d", vb_low, vb_rise, VA * HT);
        end
        n_vec++;
        if (vs_hi != VS * HT) begin
            n_err++;
            $display("FAIL vsync_width: got %0d, want %0d", vs_hi, VS * HT);
        end
        n_vec++;
        if (vs_rise - vb_rise != VF * HT) begin
            n_err++;
            $display("FAIL vsync_front_porch: got %0d, want %0d", vs_rise - vb_rise, VF * HT);
        end
        n_vec++;
        if (period != FRAME) begin
            n_err++;
            $display("FAIL frame_period: got %0d, want %0d", period, FRAME);
        end
    endtask

    task automatic test_pattern_switch();
        exp_t obs, e;
        int   f0, toggle_at, end_t, held_t, bars_seen, q, x, y;
        f0        = t / FRAME;
        toggle_at = f0 * FRAME + HT * (2 + int'($urandom_range(0, VA - 6)))
                    + int'($urandom_range(0, HT - 1));
        held_t    = f0 * FRAME + 3 + (VA - 1) * HT + 5;
        end_t     = (f0 + 2) * FRAME + 4;
        bars_seen = 0;
        while (t < end_t) begin
            if (t == toggle_at) pattern_en = 1'b1;
            if (t / FRAME == f0 + 1 && t % FRAME > 64 && $urandom_range(0, 31) == 0)
                pattern_en = ~pattern_en;
            e   = model_at(t);
            obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL pattern_stream t=%0d: got %h, want %h", t, obs, e);
            end
            if (t == held_t) begin
                n_vec++;
                if (rgb_o !== fb_model(5, VA - 1)) begin
                    n_err++;
                    $display("FAIL pattern_held_off: got %h, want %h", rgb_o, fb_model(5, VA - 1));
                end
            end
            q = t - 3;
            x = q % HT;
            y = (q / HT) % VT;
            if (q / FRAME == f0 + 1 && y == 0 && x < HA && x % 32 == 16) begin
                n_vec++;
                bars_seen++;
                if (rgb_o !== BARS[x / 32]) begin
                    n_err++;
                    $display("FAIL colour_bar x=%0d: got %h, want %h", x, rgb_o, BARS[x / 32]);
                end
            end
            @(negedge clk6m);
        end
        n_vec++;
        if (bars_seen != 8) begin
            n_err++;
            $display("FAIL colour_bar_count: got %0d, want 8", bars_seen);
        end
    endtask

    task automatic test_midframe_reset();
        exp_t obs, e;
        int   guard;
        guard = 0;
        while ((t % FRAME) != 10 * HT + 50 && guard < 2 * FRAME) begin
            e   = model_at(t);
            obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL pre_reset_stream t=%0d: got %h, want %h", t, obs, e);
            end
            @(negedge clk6m);
            guard++;
        end
        n_vec++;
        if ((t % FRAME) != 10 * HT + 50) begin
            n_err++;
            $display("FAIL reset_point_wait: got offset %0d, want %0d", t % FRAME, 10 * HT + 50);
        end
        reset = 1'b1;
        pattern_en = 1'($urandom_range(0, 1));
        @(negedge clk6m);
        reset = 1'b0;
        obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
        n_vec++;
        if (obs !== RESET_EXP) begin
            n_err++;
            $display("FAIL midframe_reset_state: got %h, want %h", obs, RESET_EXP);
        end
        for (int i = 1; i <= 3 * HT; i++) begin
            @(negedge clk6m);
            e   = model_at(t);
            obs = {hsync_o, vsync_o, hblank_o, vblank_o, frame_start, fb_rd, fb_addr, rgb_o};
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL restart_stream t=%0d: got %h, want %h", t, obs, e);
            end
            if (i == 3) begin
                n_vec++;
                if (frame_start !== 1'b1) begin
                    n_err++;
                    $display("FAIL restart_frame_start: got %b, want 1", frame_start);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        pattern_en = 1'b0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_pattern_switch();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
